// File: rtl/video_timing_detector.sv
// video_timing_detector: recovers active-area x/y from a de/hs/vs stream, measures
// line/frame geometry and locks once two consecutive complete frames agree.
module video_timing_detector #(
   parameter int CNT_W = 11
) (
   input  logic             clk_pixel,
   input  logic             reset_n,
   input  logic             de,
   input  logic             hs,
   input  logic             vs,
   output logic             de_o,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             frame_start,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_active,
   output logic             locked
);
   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
      return (v == MAX) ? v : v + ONE;
   endfunction

   state_t             state, state_n;
   logic               de_p, hs_p, vs_p;
   logic               de_rise, de_fall, hs_rise, vs_rise, wdog;
   logic [CNT_W-1:0]   hc, ly;
   logic [CNT_W-1:0]   line_len, run_len, vc, va;
   logic [CNT_W-1:0]   line_len_n, run_len_n, vc_n, va_n;
   logic               line_set, run_set, bad;
   logic               line_set_n, run_set_n, bad_n;
   logic [4*CNT_W-1:0] frame, cand;
   logic               cand_ok, good, accept, publish, cand_ld;

   assign de_rise = de & ~de_p;
   assign de_fall = ~de & de_p;
   assign hs_rise = hs & ~hs_p;
   assign vs_rise = vs & ~vs_p;
   assign wdog    = hc == MAX;
   assign frame   = {line_len, run_len, vc, va};
   assign good    = !bad && line_len != '0 && run_len != '0 && vc != '0 && va != '0;
   assign accept  = good && (state == MEASURE ? cand_ok && frame == cand
                                              : frame == {h_total, h_active, v_total, v_active});

   // Events on the vs-rise clock already belong to the new frame.
   always_comb begin
      line_len_n = vs_rise ? '0 : line_len;
      run_len_n  = vs_rise ? '0 : run_len;
      vc_n       = vs_rise ? '0 : vc;
      va_n       = vs_rise ? '0 : va;
      line_set_n = vs_rise ? 1'b0 : line_set;
      run_set_n  = vs_rise ? 1'b0 : run_set;
      bad_n      = vs_rise ? 1'b0 : bad;
      if (hs_rise) begin
         bad_n = bad_n | (vc_n == MAX);
         vc_n  = inc(vc_n);
         if (line_set_n) bad_n = bad_n | (hc != line_len_n);
         else begin
            line_len_n = hc;
            line_set_n = 1'b1;
         end
      end
      if (de_rise) begin
         bad_n = bad_n | (va_n == MAX);
         va_n  = inc(va_n);
      end
      if (de_fall) begin
         bad_n = bad_n | (x == MAX);
         if (run_set_n) bad_n = bad_n | (inc(x) != run_len_n);
         else begin
            run_len_n = inc(x);
            run_set_n = 1'b1;
         end
      end
      state_n = wdog ? SEARCH : !vs_rise ? state : state == SEARCH ? MEASURE : accept ? LOCKED : MEASURE;
      publish = !wdog && vs_rise && state == MEASURE && accept;
      cand_ld = !wdog && vs_rise && state != SEARCH && !accept;
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state       <= SEARCH;
         {de_p, hs_p, vs_p, de_o, frame_start, locked} <= '0;
         {x, y, ly, hc} <= '0;
         {line_len, run_len, vc, va, line_set, run_set, bad} <= '0;
         {cand, cand_ok} <= '0;
         {h_total, h_active, v_total, v_active} <= '0;
      end else begin
         de_p        <= de;
         hs_p        <= hs;
         vs_p        <= vs;
         de_o        <= de;
         frame_start <= vs_rise;
         x           <= de_rise ? '0 : de ? inc(x) : x;
         ly          <= vs_rise ? '0 : de_fall ? inc(ly) : ly;
         if (de) y <= ly;
         hc          <= hs_rise ? ONE : inc(hc);
         line_len    <= line_len_n;
         run_len     <= run_len_n;
         vc          <= vc_n;
         va          <= va_n;
         line_set    <= line_set_n;
         run_set     <= run_set_n;
         bad         <= bad_n;
         state       <= state_n;
         locked      <= state == LOCKED;
         if (wdog) {cand, cand_ok} <= '0;
         else if (cand_ld) begin
            cand    <= frame;
            cand_ok <= good;
         end
         if (publish) {h_total, h_active, v_total, v_active} <= frame;
      end
   end
endmodule

// File: tb/tb_video_timing_detector.sv
// tb_video_timing_detector: directed frame streams in a tiny and a medium video mode
// with hand-computed geometry, position and lock expectations.
module tb_video_timing_detector;
   localparam int W = 11;

   logic         clk_pixel = 1'b0;
   logic         reset_n = 1'b0;
   logic         de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic         de_o, frame_start, locked;
   logic [W-1:0] x, y, h_total, h_active, v_total, v_active;

   int checks = 0, errors = 0;
   int ht, ha, hs0, hs1, vt, va, vs0, vs1, vs_h;
   int fs_cnt;
   logic         last_de, first_de;
   logic [W-1:0] last_x, last_y, first_x, first_y, mid_x, mid_y;
   logic [68:0]  rst_snap;

   video_timing_detector #(.CNT_W(W)) dut (
      .clk_pixel(clk_pixel), .reset_n(reset_n), .de(de), .hs(hs), .vs(vs),
      .de_o(de_o), .x(x), .y(y), .frame_start(frame_start),
      .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
      .locked(locked)
   );

   always #5 clk_pixel = ~clk_pixel;

   task automatic set_mode(input int a, b, c, d, e, f, g, h);
      ht = a; ha = b; hs0 = c; hs1 = d; vt = e; va = f; vs0 = g; vs1 = h; vs_h = 0;
   endtask

   // One frame from line 0; optional short line and an async reset pulse at (rst_line, 5).
   task automatic frame(input int short_line, input int rst_line);
      fs_cnt = 0;
      for (int v = 0; v < vt; v++) begin
         for (int h = 0; h < ht; h++) begin
            if (!(v == short_line && h == ht - 1)) begin
               @(negedge clk_pixel);
               if (v == rst_line && h == 5) begin
                  reset_n = 1'b0;
                  #1;
                  rst_snap = {de_o, x, y, frame_start, h_total, h_active, v_total, v_active, locked};
                  #1 reset_n = 1'b1;
               end
               de = (h < ha) && (v < va);
               hs = (h >= hs0) && (h < hs1);
               vs = (v > vs0 || (v == vs0 && h >= vs_h)) && (v < vs1 || (v == vs1 && h < vs_h));
               @(posedge clk_pixel);
               #1;
               fs_cnt += int'(frame_start);
               if (h == ha - 1 && v == va - 1) begin last_de = de_o; last_x = x; last_y = y; end
               if (h == 0 && v == 0) begin first_de = de_o; first_x = x; first_y = y; end
               if (h == 5 && v == 3) begin mid_x = x; mid_y = y; end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_pixel);
         de = 1'b0; hs = 1'b0; vs = 1'b0;
         @(posedge clk_pixel);
         #1;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk_pixel);
      #1;
      checks++;
      if ({de_o, x, y, frame_start, h_total, h_active, v_total, v_active, locked} !== 69'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", {de_o, x, y, frame_start, h_total, h_active, v_total, v_active, locked});
      end
      @(negedge clk_pixel);
      reset_n = 1'b1;
      idle(2);
      checks++;
      if (locked !== 1'b0 || frame_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle locked=%0b frame_start=%0b exp=0,0", locked, frame_start);
      end
   endtask

   task automatic test_lock(input int eh, eha, ev, eva);
      frame(-1, -1);
      frame(-1, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL lock_early locked=%0b exp=0", locked); end
      frame(-1, -1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL lock_third locked=%0b exp=1", locked); end
      checks++;
      if (h_total !== W'(eh)) begin errors++; $display("FAIL lock_h_total got=%0d exp=%0d", h_total, eh); end
      checks++;
      if (h_active !== W'(eha)) begin errors++; $display("FAIL lock_h_active got=%0d exp=%0d", h_active, eha); end
      checks++;
      if (v_total !== W'(ev)) begin errors++; $display("FAIL lock_v_total got=%0d exp=%0d", v_total, ev); end
      checks++;
      if (v_active !== W'(eva)) begin errors++; $display("FAIL lock_v_active got=%0d exp=%0d", v_active, eva); end
      checks++;
      if (fs_cnt !== 1) begin errors++; $display("FAIL lock_frame_start count=%0d exp=1", fs_cnt); end
   endtask

   task automatic test_position;
      frame(-1, -1);
      checks++;
      if ({last_de, last_x, last_y} !== {1'b1, W'(ha - 1), W'(va - 1)}) begin
         errors++;
         $display("FAIL pos_last de_o=%0b x=%0d y=%0d exp=1,%0d,%0d", last_de, last_x, last_y, ha - 1, va - 1);
      end
      checks++;
      if ({first_de, first_x, first_y} !== {1'b1, W'(0), W'(0)}) begin
         errors++;
         $display("FAIL pos_first de_o=%0b x=%0d y=%0d exp=1,0,0", first_de, first_x, first_y);
      end
      checks++;
      if ({mid_x, mid_y} !== {W'(5), W'(3)}) begin
         errors++;
         $display("FAIL pos_mid x=%0d y=%0d exp=5,3", mid_x, mid_y);
      end
      checks++;
      if (locked !== 1'b1 || fs_cnt !== 1) begin
         errors++;
         $display("FAIL pos_locked locked=%0b frame_start count=%0d exp=1,1", locked, fs_cnt);
      end
   endtask

   task automatic test_simultaneous;
      vs_h = hs0;
      repeat (3) frame(-1, -1);
      checks++;
      if (locked !== 1'b1 || v_total !== W'(vt)) begin
         errors++;
         $display("FAIL simul_vs_hs locked=%0b v_total=%0d exp=1,%0d", locked, v_total, vt);
      end
      vs_h = 0;
   endtask

   task automatic test_short_line;
      frame(-1, -1);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL short_pre locked=%0b exp=1", locked); end
      frame(3, -1);
      checks++;
      if (locked !== 1'b0 || h_total !== W'(ht)) begin
         errors++;
         $display("FAIL short_drop locked=%0b h_total=%0d exp=0,%0d", locked, h_total, ht);
      end
      frame(-1, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL short_clean1 locked=%0b exp=0", locked); end
      frame(-1, -1);
      checks++;
      if (locked !== 1'b1 || h_total !== W'(ht)) begin
         errors++;
         $display("FAIL short_relock locked=%0b h_total=%0d exp=1,%0d", locked, h_total, ht);
      end
   endtask

   task automatic test_watchdog;
      idle(2030);
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL wdog_before locked=%0b exp=1", locked); end
      idle(30);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL wdog_fire locked=%0b exp=0", locked); end
      frame(-1, -1);
      frame(-1, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL wdog_early locked=%0b exp=0", locked); end
      frame(-1, -1);
      checks++;
      if (locked !== 1'b1 || h_total !== W'(ht)) begin
         errors++;
         $display("FAIL wdog_relock locked=%0b h_total=%0d exp=1,%0d", locked, h_total, ht);
      end
   endtask

   task automatic test_reset_mid;
      checks++;
      if (locked !== 1'b1) begin errors++; $display("FAIL rmid_pre locked=%0b exp=1", locked); end
      frame(-1, 3);
      checks++;
      if (rst_snap !== 69'd0) begin errors++; $display("FAIL rmid_async got=%h exp=0", rst_snap); end
      frame(-1, -1);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL rmid_early locked=%0b exp=0", locked); end
      frame(-1, -1);
      checks++;
      if (locked !== 1'b1 || h_active !== W'(ha)) begin
         errors++;
         $display("FAIL rmid_relock locked=%0b h_active=%0d exp=1,%0d", locked, h_active, ha);
      end
   endtask

   task automatic test_medium;
      set_mode(200, 160, 170, 186, 30, 20, 23, 26);
      @(negedge clk_pixel);
      reset_n = 1'b0;
      @(posedge clk_pixel);
      #1;
      checks++;
      if (h_total !== '0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL med_reset h_total=%0d locked=%0b exp=0,0", h_total, locked);
      end
      @(negedge clk_pixel);
      reset_n = 1'b1;
      test_lock(200, 160, 30, 20);
      test_position;
   endtask

   initial begin
      test_reset;
      set_mode(24, 16, 18, 21, 12, 8, 9, 11);
      test_lock(24, 16, 12, 8);
      test_position;
      test_simultaneous;
      test_short_line;
      test_watchdog;
      test_reset_mid;
      test_medium;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
